rom_port_arbiter: RTL and testbench

Shares the single combinational read port of the instruction ROM between two requesters: the fetch stage (instruction reads) and the memory stage (load instructions that target the ROM region, e.g. constant tables). It accepts at most one request per cycle, drives the ROM address, and registers the ROM output into a one-cycle-later response for the winning port. A bounded-starvation priority scheme favours the memory stage, and a flush input discards in-flight fetch results on pipeline redirects.

---
 rtl/rom_port_arbiter.sv | 98 +++++++++
 tb/tb_rom_port_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rom_port_arbiter.sv
// Fetch/data arbiter for the single ROM read port.
// Data wins by default; fetch is guaranteed a grant after a bounded streak.
module rom_port_arbiter #(
  parameter int MAX_DATA_STREAK = 4,
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  input  logic              fetch_flush,
  output logic              fetch_resp_valid,
  output logic [DATA_W-1:0] fetch_resp_data,
  input  logic              data_valid,
  input  logic [ADDR_W-1:0] data_addr,
  output logic              data_ready,
  output logic              data_resp_valid,
  output logic [DATA_W-1:0] data_resp_data,
  output logic              resp_misaligned,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_data
);

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_DATA_STREAK);

  logic [SW-1:0]     r_streak;
  logic              r_valid;
  logic              r_owner_f;
  logic              r_mis;
  logic [DATA_W-1:0] r_fdata;
  logic [DATA_W-1:0] r_ddata;

  logic              w_f_elig;
  logic              w_gf;
  logic              w_gd;
  logic              w_mis;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_cap;

  // Grant decision and ROM address mux; nothing granted while in reset.
  always_comb begin
    w_f_elig = reset_n && fetch_valid && !fetch_flush;
    w_gf     = w_f_elig && (!data_valid || (r_streak == SMAX));
    w_gd     = reset_n && data_valid && !w_gf;
    w_addr   = '0;
    unique case (1'b1)
      w_gf:    w_addr = fetch_addr;
      w_gd:    w_addr = data_addr;
      default: w_addr = '0;
    endcase
    w_mis = |w_addr[1:0];
    w_cap = w_mis ? '0 : rom_data;
  end

  // Count data wins over a waiting fetch; any other cycle restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_streak <= '0;
    end else if (w_gd && w_f_elig) begin
      r_streak <= (r_streak == SMAX) ? SMAX : r_streak + 1'b1;
    end else begin
      r_streak <= '0;
    end
  end

  // Response register: owner, misalignment and data captured on the grant edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid   <= 1'b0;
      r_owner_f <= 1'b0;
      r_mis     <= 1'b0;
      r_fdata   <= '0;
      r_ddata   <= '0;
    end else begin
      r_valid   <= w_gf | w_gd;
      r_owner_f <= w_gf;
      r_mis     <= w_mis;
      if (w_gf) r_fdata <= w_cap;
      if (w_gd) r_ddata <= w_cap;
    end
  end

  // A flush in the response cycle suppresses only the fetch response.
  always_comb begin
    fetch_ready      = w_gf;
    data_ready       = w_gd;
    rom_address      = w_addr;
    fetch_resp_valid = r_valid && r_owner_f && !fetch_flush;
    data_resp_valid  = r_valid && !r_owner_f;
    fetch_resp_data  = r_fdata;
    data_resp_data   = r_ddata;
    resp_misaligned  = r_mis && (fetch_resp_valid || data_resp_valid);
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Randomized + directed bench for rom_port_arbiter.
// Reference model: streak count and one pending response slot.
module tb_rom_port_arbiter;

  localparam int MAX = 4;

  logic        clk;
  logic        reset_n;
  logic        fetch_valid;
  logic [15:0] fetch_addr;
  logic        fetch_ready;
  logic        fetch_flush;
  logic        fetch_resp_valid;
  logic [31:0] fetch_resp_data;
  logic        data_valid;
  logic [15:0] data_addr;
  logic        data_ready;
  logic        data_resp_valid;
  logic [31:0] data_resp_data;
  logic        resp_misaligned;
  logic [15:0] rom_address;
  logic [31:0] rom_data;

  int n_tests = 0;
  int n_fail  = 0;

  int          m_streak;
  bit          m_gf, m_gd;
  bit          p_v, p_f, p_m;
  logic [31:0] p_d;
  bit          got_fr;

  rom_port_arbiter #(
    .MAX_DATA_STREAK(MAX),
    .ADDR_W(16),
    .DATA_W(32)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .fetch_valid(fetch_valid),
    .fetch_addr(fetch_addr),
    .fetch_ready(fetch_ready),
    .fetch_flush(fetch_flush),
    .fetch_resp_valid(fetch_resp_valid),
    .fetch_resp_data(fetch_resp_data),
    .data_valid(data_valid),
    .data_addr(data_addr),
    .data_ready(data_ready),
    .data_resp_valid(data_resp_valid),
    .data_resp_data(data_resp_data),
    .resp_misaligned(resp_misaligned),
    .rom_address(rom_address),
    .rom_data(rom_data)
  );

  function automatic logic [31:0] rom_word(input logic [15:0] a);
    logic [13:0] idx;
    idx = a[15:2];
    if (idx == 14'd0) return 32'h0000_0013;
    if (idx == 14'd1) return 32'h1234_5678;
    return 32'hC0DE_0000 | {18'd0, idx};
  endfunction

  assign rom_data = rom_word(rom_address);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at posedge+1: drive, check mid-cycle, advance model at the edge.
  task automatic step(input bit fv, input logic [15:0] fa, input bit ff,
                      input bit dv, input logic [15:0] da);
    bit          fe;
    bit          vis_f;
    logic [15:0] ea;
    fetch_valid = fv;
    fetch_addr  = fa;
    fetch_flush = ff;
    data_valid  = dv;
    data_addr   = da;
    fe = fv && !ff;
    if (fe && dv) begin
      m_gf = (m_streak >= MAX);
      m_gd = !m_gf;
    end else begin
      m_gf = fe;
      m_gd = dv;
    end
    ea = m_gf ? fa : (m_gd ? da : 16'd0);
    vis_f = p_v && p_f && !ff;
    #4;
    got_fr = fetch_ready;
    chk("f_ready", {31'd0, fetch_ready}, {31'd0, m_gf});
    chk("d_ready", {31'd0, data_ready}, {31'd0, m_gd});
    chk("rom_addr", {16'd0, rom_address}, {16'd0, ea});
    chk("f_rvalid", {31'd0, fetch_resp_valid}, {31'd0, vis_f});
    chk("d_rvalid", {31'd0, data_resp_valid}, {31'd0, p_v && !p_f});
    chk("misalign", {31'd0, resp_misaligned},
        {31'd0, p_m && (vis_f || (p_v && !p_f))});
    if (vis_f) chk("f_rdata", fetch_resp_data, p_d);
    if (p_v && !p_f) chk("d_rdata", data_resp_data, p_d);
    @(posedge clk);
    p_v = m_gf || m_gd;
    p_f = m_gf;
    p_m = (ea[1:0] != 2'b00);
    p_d = p_m ? 32'd0 : rom_word(ea);
    if (fe && m_gd) m_streak = (m_streak + 1 > MAX) ? MAX : m_streak + 1;
    else m_streak = 0;
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_frdy"}, {31'd0, fetch_ready}, 32'd0);
    chk({tag, "_drdy"}, {31'd0, data_ready}, 32'd0);
    chk({tag, "_frv"}, {31'd0, fetch_resp_valid}, 32'd0);
    chk({tag, "_drv"}, {31'd0, data_resp_valid}, 32'd0);
    chk({tag, "_mis"}, {31'd0, resp_misaligned}, 32'd0);
    chk({tag, "_addr"}, {16'd0, rom_address}, 32'd0);
  endtask

  bit          rfv, rdv, rff;
  logic [15:0] rfa, rda;
  bit          last_gf, last_gd;

  initial begin
    reset_n     = 1'b0;
    fetch_valid = 1'b1;
    fetch_addr  = 16'h4;
    fetch_flush = 1'b0;
    data_valid  = 1'b1;
    data_addr   = 16'h8;
    m_streak = 0;
    p_v = 0; p_f = 0; p_m = 0; p_d = '0;
    #2;
    chk_all_zero("rst");
    chk("rst_fdata", fetch_resp_data, 32'd0);
    chk("rst_ddata", data_resp_data, 32'd0);
    @(posedge clk);
    #1;
    chk_all_zero("rst2");
    reset_n = 1'b1;

    // first fetch of word0 and its single-cycle response
    step(1, 16'h0, 0, 0, 16'h0);
    step(0, 16'h0, 0, 0, 16'h0);
    step(0, 16'h0, 0, 0, 16'h0);

    // alternating single requests, idle gaps
    step(1, 16'h0, 0, 0, 16'h0);
    step(0, 16'h0, 0, 1, 16'h4);
    step(1, 16'h8, 0, 0, 16'h0);
    step(0, 16'h0, 0, 0, 16'h0);
    step(0, 16'h0, 0, 0, 16'h0);

    // misaligned data read
    step(0, 16'h0, 0, 1, 16'h6);
    step(0, 16'h0, 0, 0, 16'h0);

    // fetch response flushed; data granted in flush cycle still answers
    step(1, 16'h4, 0, 0, 16'h0);
    step(0, 16'h0, 1, 1, 16'h8);
    step(0, 16'h0, 0, 0, 16'h0);
    // data response unaffected by flush
    step(0, 16'h0, 0, 1, 16'hC);
    step(0, 16'h0, 1, 0, 16'h0);
    step(0, 16'h0, 0, 0, 16'h0);

    // both valid continuously: D,D,D,D,F repeating
    for (int i = 0; i < 10; i++) begin
      step(1, 16'h10, 0, 1, 16'(16'h20 + 4 * i));
      chk("ddddf", {31'd0, got_fr}, {31'd0, (i % 5) == 4});
    end
    step(0, 16'h0, 0, 0, 16'h0);

    // async reset mid-streak, with one response showing and one grant pending
    step(1, 16'h10, 0, 1, 16'h40);
    step(1, 16'h10, 0, 1, 16'h44);
    fetch_valid = 1'b1;
    data_valid  = 1'b1;
    data_addr   = 16'h48;
    #1;
    chk("pre_rst_drv", {31'd0, data_resp_valid}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk_all_zero("arst");
    p_v = 0;
    m_streak = 0;
    @(posedge clk);
    #1;
    chk_all_zero("arst2");
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1, 16'h10, 0, 1, 16'(16'h60 + 4 * i));
      chk("post_rst", {31'd0, got_fr}, {31'd0, i == 4});
    end
    step(0, 16'h0, 0, 0, 16'h0);

    // randomized traffic with holding requesters
    rfv = 0; rdv = 0; rfa = '0; rda = '0;
    last_gf = 1; last_gd = 1;
    for (int c = 0; c < 600; c++) begin
      if (!rfv || last_gf) begin
        rfv = ($urandom_range(0, 3) != 0);
        rfa = 16'($urandom_range(0, 127));
      end else if ($urandom_range(0, 19) == 0) begin
        rfv = 0;
      end
      if (!rdv || last_gd) begin
        rdv = ($urandom_range(0, 2) != 0);
        rda = 16'($urandom_range(0, 127));
      end else if ($urandom_range(0, 19) == 0) begin
        rdv = 0;
      end
      rff = ($urandom_range(0, 9) == 0);
      step(rfv, rfa, rff, rdv, rda);
      last_gf = m_gf;
      last_gd = m_gd;
    end
    step(0, 16'h0, 0, 0, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
